// File: rtl/cci_mpf_prim_lutram_rmw_arb_pkg.sv
// Shared types for the LUTRAM read-modify-write arbiter.
// Bundle fields are sized to maximum widths; users take the low bits.
package cci_mpf_prim_lutram_rmw_arb_pkg;

  localparam int RMW_MAX_IDX_BITS   = 16;
  localparam int RMW_MAX_DATA_BITS  = 64;
  localparam int RMW_MAX_REQID_BITS = 8;

  typedef logic [RMW_MAX_IDX_BITS-1:0]   rmw_idx_t;
  typedef logic [RMW_MAX_DATA_BITS-1:0]  rmw_data_t;
  typedef logic [RMW_MAX_REQID_BITS-1:0] rmw_reqid_t;

  typedef struct packed {
    rmw_reqid_t reqid;
    rmw_idx_t   idx;
    rmw_data_t  delta;
  } rmw_req_t;

  typedef struct packed {
    logic      valid;
    rmw_req_t  req;
    rmw_data_t old_val;
  } rmw_s1_t;

  typedef struct packed {
    rmw_reqid_t reqid;
    rmw_idx_t   idx;
    rmw_data_t  old_val;
    rmw_data_t  new_val;
    logic       sat;
  } rmw_rsp_t;

  typedef enum logic {
    INIT_BUSY  = 1'b0,
    INIT_READY = 1'b1
  } init_state_t;

  function automatic int rmw_reqid_bits(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_lutram_init.sv
// LUTRAM with async read, sync write and post-reset fill to INIT_VALUE.
// Ports: clk, reset, rdy, raddr/rdata, wen/waddr/wdata.
module cci_mpf_prim_lutram_init
  import cci_mpf_prim_lutram_rmw_arb_pkg::*;
#(
  parameter int N_ENTRIES = 32,
  parameter int N_DATA_BITS = 16,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0,
  parameter string READ_DURING_WRITE = "NEW_DATA",
  localparam int IDX_BITS = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rdy,
  input  logic [IDX_BITS-1:0]    raddr,
  output logic [N_DATA_BITS-1:0] rdata,
  input  logic                   wen,
  input  logic [IDX_BITS-1:0]    waddr,
  input  logic [N_DATA_BITS-1:0] wdata
);

  localparam bit BYPASS = (READ_DURING_WRITE == "NEW_DATA");

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  init_state_t            state_q, state_d;
  logic [IDX_BITS-1:0]    init_idx_q, init_idx_d;
  logic                   mem_wen;
  logic [IDX_BITS-1:0]    mem_waddr;
  logic [N_DATA_BITS-1:0] mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT_BUSY;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    mem_wen    = wen;
    mem_waddr  = waddr;
    mem_wdata  = wdata;
    unique case (state_q)
      INIT_BUSY: begin
        mem_wen    = 1'b1;
        mem_waddr  = init_idx_q;
        mem_wdata  = INIT_VALUE;
        init_idx_d = init_idx_q + IDX_BITS'(1);
        if (&init_idx_q) state_d = INIT_READY;
      end
      INIT_READY: begin
      end
      default: state_d = INIT_BUSY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
  end

  // Forward the write port so a same-cycle read sees the new value.
  assign rdata = (BYPASS && mem_wen && (mem_waddr == raddr))
               ? mem_wdata : mem[raddr];

  assign rdy = (state_q == INIT_READY);

endmodule

// File: rtl/cci_mpf_prim_lutram_rmw_arb.sv
// Round-robin arbitrated saturating counter table (read, add, write).
// Ports: clk, reset, rdy, req_valid/idx/delta, req_grant, rsp_*.
module cci_mpf_prim_lutram_rmw_arb
  import cci_mpf_prim_lutram_rmw_arb_pkg::*;
#(
  parameter int N_ENTRIES = 32,
  parameter int N_DATA_BITS = 16,
  parameter int N_DELTA_BITS = 8,
  parameter int N_REQ = 2,
  localparam int IDX_BITS = $clog2(N_ENTRIES),
  localparam int REQID_BITS = rmw_reqid_bits(N_REQ)
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               rdy,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ-1:0][IDX_BITS-1:0]     req_idx,
  input  logic [N_REQ-1:0][N_DELTA_BITS-1:0] req_delta,
  output logic [N_REQ-1:0]                   req_grant,
  output logic                               rsp_valid,
  output logic [REQID_BITS-1:0]              rsp_reqid,
  output logic [IDX_BITS-1:0]                rsp_idx,
  output logic [N_DATA_BITS-1:0]             rsp_old,
  output logic [N_DATA_BITS-1:0]             rsp_new,
  output logic                               rsp_sat
);

  localparam int SUM_BITS = N_DATA_BITS + 2;

  logic [REQID_BITS-1:0]   ptr_q;
  logic [REQID_BITS-1:0]   gnt_id;
  logic                    gnt_any;
  rmw_req_t                s0_req;
  rmw_s1_t                 s1_q;
  rmw_rsp_t                rsp;
  logic [N_DATA_BITS-1:0]  rd_data;
  logic                    wen;
  logic [N_DELTA_BITS-1:0] s1_delta;
  logic [N_DATA_BITS-1:0]  s1_old;
  logic [SUM_BITS-1:0]     sum;
  logic                    neg;
  logic                    ovf;
  logic                    s1_unused;
  logic                    rsp_unused;

  always_comb begin : arb
    logic [REQID_BITS-1:0] slot;
    req_grant = '0;
    gnt_id    = '0;
    gnt_any   = 1'b0;
    slot      = '0;
    if (rdy) begin
      for (int k = 0; k < N_REQ; k++) begin
        slot = REQID_BITS'((int'(ptr_q) + k) % N_REQ);
        if (!gnt_any && req_valid[slot]) begin
          gnt_any         = 1'b1;
          gnt_id          = slot;
          req_grant[slot] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (int'(gnt_id) == N_REQ - 1)
             ? '0 : gnt_id + REQID_BITS'(1);
    end
  end

  assign s0_req.reqid = RMW_MAX_REQID_BITS'(gnt_id);
  assign s0_req.idx   = RMW_MAX_IDX_BITS'(req_idx[gnt_id]);
  assign s0_req.delta = RMW_MAX_DATA_BITS'(req_delta[gnt_id]);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q.valid <= 1'b0;
    end else begin
      s1_q.valid   <= gnt_any;
      s1_q.req     <= s0_req;
      s1_q.old_val <= RMW_MAX_DATA_BITS'(rd_data);
    end
  end

  assign s1_delta = s1_q.req.delta[N_DELTA_BITS-1:0];
  assign s1_old   = s1_q.old_val[N_DATA_BITS-1:0];

  // Two guard bits: the top one flags a negative sum, the next overflow.
  assign sum = {2'b00, s1_old}
             + {{(SUM_BITS-N_DELTA_BITS){s1_delta[N_DELTA_BITS-1]}},
                s1_delta};
  assign neg = sum[SUM_BITS-1];
  assign ovf = !neg && sum[N_DATA_BITS];

  always_comb begin
    rsp         = '0;
    rsp.reqid   = s1_q.req.reqid;
    rsp.idx     = s1_q.req.idx;
    rsp.old_val = s1_q.old_val;
    rsp.sat     = neg | ovf;
    if (neg) begin
      rsp.new_val = '0;
    end else if (ovf) begin
      rsp.new_val = RMW_MAX_DATA_BITS'({N_DATA_BITS{1'b1}});
    end else begin
      rsp.new_val = RMW_MAX_DATA_BITS'(sum[N_DATA_BITS-1:0]);
    end
  end

  // A reset arriving while S1 is full drops that update entirely.
  assign wen       = s1_q.valid && !reset;
  assign rsp_valid = wen;
  assign rsp_reqid = rsp.reqid[REQID_BITS-1:0];
  assign rsp_idx   = rsp.idx[IDX_BITS-1:0];
  assign rsp_old   = rsp.old_val[N_DATA_BITS-1:0];
  assign rsp_new   = rsp.new_val[N_DATA_BITS-1:0];
  assign rsp_sat   = rsp.sat;

  assign s1_unused  = ^s1_q;
  assign rsp_unused = ^rsp;

  cci_mpf_prim_lutram_init #(
    .N_ENTRIES         (N_ENTRIES),
    .N_DATA_BITS       (N_DATA_BITS),
    .INIT_VALUE        ('0),
    .READ_DURING_WRITE ("NEW_DATA")
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .rdy   (rdy),
    .raddr (req_idx[gnt_id]),
    .rdata (rd_data),
    .wen   (wen),
    .waddr (rsp_idx),
    .wdata (rsp_new)
  );

endmodule

// File: tb/tb_cci_mpf_prim_lutram_rmw_arb.sv
// Scoreboard bench for cci_mpf_prim_lutram_rmw_arb (default params).
// A cycle model predicts grants and responses; stimulus checks phases.
module tb_cci_mpf_prim_lutram_rmw_arb;

  typedef struct {
    logic [0:0]  reqid;
    logic [4:0]  idx;
    logic [15:0] old_v;
    logic [15:0] new_v;
    logic        sat;
  } rsp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rdy;
  logic [1:0]      req_valid = '0;
  logic [1:0][4:0] req_idx = '0;
  logic [1:0][7:0] req_delta = '0;
  logic [1:0]      req_grant;
  logic            rsp_valid;
  logic [0:0]      rsp_reqid;
  logic [4:0]      rsp_idx;
  logic [15:0]     rsp_old;
  logic [15:0]     rsp_new;
  logic            rsp_sat;

  int n_checks = 0;
  int n_fail = 0;

  rsp_t       sb[$];
  rsp_t       obs[$];
  logic [1:0] glog[$];

  logic [15:0] m_mem [32];
  logic        m_known = 1'b0;
  logic        m_rdy = 1'b0;
  int          m_cnt = 0;
  int          m_ptr = 0;

  always #5 clk = ~clk;

  cci_mpf_prim_lutram_rmw_arb dut (
    .clk       (clk),
    .reset     (reset),
    .rdy       (rdy),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_delta (req_delta),
    .req_grant (req_grant),
    .rsp_valid (rsp_valid),
    .rsp_reqid (rsp_reqid),
    .rsp_idx   (rsp_idx),
    .rsp_old   (rsp_old),
    .rsp_new   (rsp_new),
    .rsp_sat   (rsp_sat)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : model
    rsp_t       e;
    rsp_t       o;
    logic [1:0] eg;
    int         gi;
    int         slot;
    int         s;
    #2;
    if (m_known) begin
      check("rdy", rdy, m_rdy);
      if (reset) begin
        check("rsp_valid_in_reset", rsp_valid, 0);
        sb.delete();
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, 1);
        if (rsp_valid) begin
          check("rsp_reqid", rsp_reqid, e.reqid);
          check("rsp_idx", rsp_idx, e.idx);
          check("rsp_old", rsp_old, e.old_v);
          check("rsp_new", rsp_new, e.new_v);
          check("rsp_sat", rsp_sat, e.sat);
          o.reqid = rsp_reqid;
          o.idx   = rsp_idx;
          o.old_v = rsp_old;
          o.new_v = rsp_new;
          o.sat   = rsp_sat;
          obs.push_back(o);
        end
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
      end
      eg = '0;
      gi = 0;
      if (m_rdy) begin
        for (int k = 0; k < 2; k++) begin
          slot = (m_ptr + k) % 2;
          if (eg == 2'b00 && req_valid[slot]) begin
            eg[slot] = 1'b1;
            gi = slot;
          end
        end
      end
      check("req_grant", req_grant, eg);
      glog.push_back(req_grant);
      if (eg != 2'b00 && !reset) begin
        e.reqid = gi[0];
        e.idx   = req_idx[gi];
        e.old_v = m_mem[req_idx[gi]];
        s = int'(e.old_v) + int'($signed(req_delta[gi]));
        if (s < 0) begin
          e.new_v = 16'd0;
          e.sat   = 1'b1;
        end else if (s > 65535) begin
          e.new_v = 16'hffff;
          e.sat   = 1'b1;
        end else begin
          e.new_v = s[15:0];
          e.sat   = 1'b0;
        end
        m_mem[e.idx] = e.new_v;
        sb.push_back(e);
        m_ptr = (gi + 1) % 2;
      end
    end
    if (reset) begin
      m_known = 1'b1;
      m_rdy   = 1'b0;
      m_cnt   = 0;
      m_ptr   = 0;
      foreach (m_mem[i]) m_mem[i] = 16'd0;
    end else if (m_known && !m_rdy) begin
      m_cnt++;
      if (m_cnt == 32) m_rdy = 1'b1;
    end
  end

  task automatic rmw(input int r, input int idx, input int d,
                     output rsp_t res);
    obs.delete();
    req_valid[r] = 1'b1;
    req_idx[r]   = idx[4:0];
    req_delta[r] = d[7:0];
    @(negedge clk);
    req_valid[r] = 1'b0;
    @(negedge clk);
    check("rmw_rsp_count", obs.size(), 1);
    if (obs.size() > 0) res = obs[0];
    else res = '{default: '0};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rsp_t r;
    int   n;

    repeat (3) @(negedge clk);
    reset        = 1'b0;
    req_valid[0] = 1'b1;
    req_idx[0]   = 5'd10;
    req_delta[0] = 8'd0;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rdy_latency", n, 32);
    #1 check("grant_at_rdy", req_grant, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);

    obs.delete();
    for (int e = 0; e < 32; e++) begin
      req_valid[0] = 1'b1;
      req_idx[0]   = e[4:0];
      req_delta[0] = 8'd0;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("sweep_count", obs.size(), 32);
    foreach (obs[i]) begin
      check("sweep_old", obs[i].old_v, 0);
      check("sweep_idx", obs[i].idx, i);
    end

    obs.delete();
    req_valid[0] = 1'b1;
    req_idx[0]   = 5'd5;
    req_delta[0] = 8'd3;
    repeat (3) @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("b2b_count", obs.size(), 3);
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      check("b2b_old", obs[i].old_v, 3 * i);
      check("b2b_new", obs[i].new_v, 3 * (i + 1));
      check("b2b_sat", obs[i].sat, 0);
    end

    rmw(1, 0, 0, r);
    check("rr_prep_reqid", r.reqid, 1);
    glog.delete();
    req_valid    = 2'b11;
    req_idx[0]   = 5'd1;
    req_idx[1]   = 5'd2;
    req_delta[0] = 8'd1;
    req_delta[1] = 8'd1;
    repeat (8) @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    check("rr_log_size", glog.size() >= 8, 1);
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
      check("rr_grant", glog[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    rmw(0, 1, 0, r);
    check("rr_entry1", r.old_v, 4);
    rmw(0, 2, 0, r);
    check("rr_entry2", r.old_v, 4);

    rmw(0, 7, 2, r);
    rmw(0, 7, -5, r);
    check("lo_old", r.old_v, 2);
    check("lo_new", r.new_v, 0);
    check("lo_sat", r.sat, 1);
    repeat (515) rmw(0, 7, 127, r);
    rmw(0, 7, 125, r);
    check("hi_pre_new", r.new_v, 65530);
    check("hi_pre_sat", r.sat, 0);
    rmw(0, 7, 10, r);
    check("hi_new", r.new_v, 65535);
    check("hi_sat", r.sat, 1);
    rmw(0, 7, -1, r);
    check("hi_dec_new", r.new_v, 65534);
    check("hi_dec_sat", r.sat, 0);

    rmw(0, 3, 5, r);
    check("rst_pre_new", r.new_v, 5);
    reset        = 1'b1;
    req_valid[0] = 1'b1;
    req_idx[0]   = 5'd3;
    req_delta[0] = 8'd1;
    #1 check("rst_grant", req_grant, 2'b01);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;
    #3 check("rst_no_rsp", rsp_valid, 0);
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reinit_latency", n, 32);
    rmw(0, 3, 0, r);
    check("rst_entry3", r.old_v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
